// File: rtl/ascon_hash_arbiter.sv
// ascon_hash_arbiter: shares one Ascon hash core between two 64-bit word-stream requesters.
// Latency: grant one cycle after valid in IDLE; word to core one cycle after handshake; result one cycle after core_hash_ready.
// Backpressure: only the owner sees ready, and only while in SEND; the owner is locked until its digest returns.
// Ports: req0_*/req1_* requester streams (valid/ready, data, last); core_* word/ack/digest path to the hash core;
//        res_* tagged digest result (one-cycle res_valid); grant one-hot owner; busy when not idle.
// Optional feature: define ARB_TIMEOUT_EN to enable the WAIT_ACK/WAIT_HASH watchdog (limit TIMEOUT_CYCLES).
module ascon_hash_arbiter #(
  parameter int MAX_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [63:0]  req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [63:0]  req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic [63:0]  core_msg,
  output logic         core_msg_valid,
  output logic         core_msg_start,
  output logic         core_msg_last,
  input  logic         core_word_ack,
  input  logic         core_hash_ready,
  input  logic [255:0] core_hash_in,
  output logic [255:0] res_hash,
  output logic         res_valid,
  output logic         res_id,
  output logic         res_err,
  output logic [1:0]   grant,
  output logic         busy
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_HASH} state_t;

  state_t          state, state_nxt;
  logic            rr;          // requester preferred on the next contended arbitration
  logic            last_pend;   // word currently awaiting ack closes the message
  logic            trunc;       // length guard forced a last in this message
  logic [CW-1:0]   word_cnt;

  logic            sel_valid, sel_last, pick, hs, at_limit, last_eff;
  logic            ack_taken, hash_taken, to_taken, timeout;
  logic [63:0]     sel_data;

  assign req0_ready = (state == SEND) && grant[0];
  assign req1_ready = (state == SEND) && grant[1];
  assign busy       = (state != IDLE);

  always_comb begin
    sel_valid  = grant[1] ? req1_valid : req0_valid;
    sel_data   = grant[1] ? req1_data  : req0_data;
    sel_last   = grant[1] ? req1_last  : req0_last;
    // Contention goes to rr; a lone requester wins regardless of rr.
    pick       = (req0_valid && req1_valid) ? rr : req1_valid;
    hs         = (state == SEND) && sel_valid;
    at_limit   = (word_cnt == CNT_LAST);
    last_eff   = sel_last || at_limit;
    ack_taken  = (state == WAIT_ACK) && core_word_ack;
    hash_taken = (state == WAIT_HASH) && core_hash_ready;
    // A real ack or digest in the same cycle beats the watchdog.
    to_taken   = timeout && !ack_taken && !hash_taken;

    state_nxt = state;
    case (state)
      IDLE:      if (req0_valid || req1_valid) state_nxt = SEND;
      SEND:      if (hs) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (core_word_ack) state_nxt = last_pend ? WAIT_HASH : SEND;
        else if (timeout)  state_nxt = IDLE;
      end
      WAIT_HASH: if (core_hash_ready || timeout) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_cnt;

  // Restarts on every state change so each wait state gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        wd_cnt <= '0;
    else if (state_nxt != state)                       wd_cnt <= '0;
    else if (state == WAIT_ACK || state == WAIT_HASH)  wd_cnt <= wd_cnt + WW'(1);
  end

  assign timeout = (state == WAIT_ACK || state == WAIT_HASH) && (wd_cnt == WD_LAST);
`else
  // Without the watchdog the wait states only exit on core events; TIMEOUT_CYCLES has no effect.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_msg       <= '0;
      core_msg_valid <= 1'b0;
      core_msg_start <= 1'b0;
      core_msg_last  <= 1'b0;
      res_hash       <= '0;
      res_valid      <= 1'b0;
      res_id         <= 1'b0;
      res_err        <= 1'b0;
      grant          <= 2'b00;
      rr             <= 1'b0;
      last_pend      <= 1'b0;
      trunc          <= 1'b0;
      word_cnt       <= '0;
    end else begin
      core_msg_valid <= 1'b0;
      core_msg_start <= 1'b0;
      core_msg_last  <= 1'b0;
      res_valid      <= 1'b0;

      if (state == IDLE && (req0_valid || req1_valid))
        grant <= pick ? 2'b10 : 2'b01;

      if (hs) begin
        core_msg       <= sel_data;
        core_msg_valid <= 1'b1;
        core_msg_start <= (word_cnt == '0);
        core_msg_last  <= last_eff;
        last_pend      <= last_eff;
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CW'(1);
        // Only a last the requester did not ask for counts as truncation.
        if (at_limit && !sel_last) trunc <= 1'b1;
      end

      if (hash_taken || to_taken) begin
        res_valid <= 1'b1;
        res_id    <= grant[1];
        res_err   <= to_taken ? 1'b1 : trunc;
        res_hash  <= to_taken ? '0 : core_hash_in;
        rr        <= ~grant[1];
        grant     <= 2'b00;
        word_cnt  <= '0;
        trunc     <= 1'b0;
        last_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_hash_arbiter.sv
// Bench for ascon_hash_arbiter: acts as both requesters and as the hash core,
// with queues of expected core words and results checked as the DUT emits them.
module tb_ascon_hash_arbiter;
  localparam int MAXW = 8;
  localparam int TO   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_last, req0_ready;
  logic [63:0]  req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [63:0]  req1_data;
  logic [63:0]  core_msg;
  logic         core_msg_valid, core_msg_start, core_msg_last;
  logic         core_word_ack, core_hash_ready;
  logic [255:0] core_hash_in, res_hash;
  logic         res_valid, res_id, res_err;
  logic [1:0]   grant;
  logic         busy;

  always #5 clk = ~clk;

  ascon_hash_arbiter #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .core_msg(core_msg), .core_msg_valid(core_msg_valid), .core_msg_start(core_msg_start),
    .core_msg_last(core_msg_last), .core_word_ack(core_word_ack), .core_hash_ready(core_hash_ready),
    .core_hash_in(core_hash_in), .res_hash(res_hash), .res_valid(res_valid), .res_id(res_id),
    .res_err(res_err), .grant(grant), .busy(busy)
  );

  typedef struct packed { logic [63:0] d; logic s; logic l; } word_t;
  typedef struct packed { logic [255:0] h; logic id; logic err; } res_t;

  word_t exp_w[$];
  res_t  exp_r[$];
  word_t mw;
  res_t  mr;
  int checks = 0;
  int failures = 0;

  // Scoreboard: compare every emitted word/result against the queued expectation.
  always @(negedge clk) begin
    if (core_msg_valid === 1'b1) begin
      checks++;
      if (exp_w.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected got data=%h start=%b last=%b", core_msg, core_msg_start, core_msg_last);
      end else begin
        mw = exp_w.pop_front();
        if (core_msg !== mw.d || core_msg_start !== mw.s || core_msg_last !== mw.l) begin
          failures++;
          $display("FAIL word got data=%h start=%b last=%b want data=%h start=%b last=%b",
                   core_msg, core_msg_start, core_msg_last, mw.d, mw.s, mw.l);
        end
      end
    end
    if (res_valid === 1'b1) begin
      checks++;
      if (exp_r.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got id=%b err=%b hash=%h", res_id, res_err, res_hash);
      end else begin
        mr = exp_r.pop_front();
        if (res_hash !== mr.h || res_id !== mr.id || res_err !== mr.err) begin
          failures++;
          $display("FAIL result got id=%b err=%b hash=%h want id=%b err=%b hash=%h",
                   res_id, res_err, res_hash, mr.id, mr.err, mr.h);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_last = 0;
    core_word_ack = 0; core_hash_ready = 0; core_hash_in = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic push_w(input logic [63:0] d, input logic s, input logic l);
    word_t w;
    w.d = d; w.s = s; w.l = l;
    exp_w.push_back(w);
  endtask

  task automatic push_r(input logic [255:0] h, input logic id, input logic err);
    res_t r;
    r.h = h; r.id = id; r.err = err;
    exp_r.push_back(r);
  endtask

  // Present one word and hold it until the handshake; returns in the cycle the word reaches the core.
  task automatic send_word(input logic p, input logic [63:0] d, input logic l);
    if (p) begin req1_valid = 1; req1_data = d; req1_last = l; end
    else   begin req0_valid = 1; req0_data = d; req0_last = l; end
    for (int i = 0; i < 50; i++) begin
      if ((p ? req1_ready : req0_ready) === 1'b1) break;
      tick();
    end
    if ((p ? req1_ready : req0_ready) !== 1'b1) begin
      $display("FAIL ready_timeout req%0d ready never rose", p);
      $fatal(1);
    end
    tick();
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic core_ack(input int delay);
    repeat (delay) tick();
    core_word_ack = 1;
    tick();
    core_word_ack = 0;
  endtask

  task automatic core_hash(input logic [255:0] h);
    core_hash_in = h;
    core_hash_ready = 1;
    tick();
    core_hash_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #1;
    checks++;
    if ({core_msg, core_msg_valid, core_msg_start, core_msg_last, res_hash, res_valid, res_id, res_err,
         grant, busy, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b busy=%b msg=%h res=%h want all zero", grant, busy, core_msg, res_hash);
    end
    tick(); tick();
    rst_n = 1;
    tick();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got grant=%b busy=%b want 00 0", grant, busy);
    end
  endtask

  task automatic test_single();
    logic [255:0] h;
    h = {32{8'hAB}};
    push_w(64'h11, 1, 0);
    push_w(64'h22, 0, 1);
    req0_valid = 1; req0_data = 64'h11; req0_last = 0;
    tick();
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL grant_latency got grant=%b busy=%b rdy0=%b rdy1=%b want 01 1 1 0", grant, busy, req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (core_msg_valid !== 1'b1) begin
      failures++;
      $display("FAIL word_latency got core_msg_valid=%b want 1", core_msg_valid);
    end
    core_ack(3);
    send_word(0, 64'h22, 1);
    core_ack(3);
    push_r(h, 0, 0);
    core_hash(h);
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL result_latency got res_valid=%b busy=%b grant=%b want 1 0 00", res_valid, busy, grant);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL result_pulse got res_valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_contention();
    logic       exp_owner;
    logic [1:0] exp_g;
    logic [63:0] d;
    rst_n = 0;
    clear_inputs();
    req0_valid = 1; req0_last = 1;
    req1_valid = 1; req1_last = 1;
    tick(); tick();
    rst_n = 1;
    for (int r = 0; r < 4; r++) begin
      req0_data = 64'hA0 + 64'(r);
      req1_data = 64'hB0 + 64'(r);
      exp_owner = r[0];
      exp_g = exp_owner ? 2'b10 : 2'b01;
      d = exp_owner ? req1_data : req0_data;
      push_w(d, 1, 1);
      push_r({8{32'hC0DE0000 + 32'(r)}}, exp_owner, 0);
      for (int i = 0; i < 20; i++) begin
        if (req0_ready === 1'b1 || req1_ready === 1'b1) break;
        tick();
      end
      checks++;
      if ({req1_ready, req0_ready} !== exp_g) begin
        failures++;
        $display("FAIL contention_round%0d got ready=%b want %b", r, {req1_ready, req0_ready}, exp_g);
      end
      tick();
      core_ack(1);
      core_hash({8{32'hC0DE0000 + 32'(r)}});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_truncation();
    logic [63:0] d;
    for (int i = 0; i < 9; i++) begin
      d = 64'h100 + 64'(i);
      push_w(d, (i == 0) || (i == 8), (i == 7) || (i == 8));
      send_word(1, d, i == 8);
      core_ack(1);
      if (i == 7 || i == 8) begin
        push_r({4{64'h7700 + 64'(i)}}, 1, i == 7);
        core_hash({4{64'h7700 + 64'(i)}});
        checks++;
        if (res_valid !== 1'b1) begin
          failures++;
          $display("FAIL trunc_result_word%0d got res_valid=%b want 1", i + 1, res_valid);
        end
      end
    end
    req1_last = 0;
    tick();
  endtask

  task automatic test_stray_stall();
    logic bad_stall;
    push_w(64'h5A5A, 1, 0);
    push_w(64'hA5A5, 0, 1);
    send_word(0, 64'h5A5A, 0);
    tick();
    core_hash_ready = 1;
    core_hash_in = {8{32'hDEADBEEF}};
    tick();
    core_hash_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stray_hash got res_valid=%b busy=%b want 0 1", res_valid, busy);
    end
    core_word_ack = 1;
    core_hash_ready = 1;
    tick();
    core_word_ack = 0;
    core_hash_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL ack_with_hash got res_valid=%b rdy0=%b want 0 1", res_valid, req0_ready);
    end
    bad_stall = 0;
    for (int i = 0; i < 4; i++) begin
      if (req0_ready !== 1'b1 || core_msg_valid !== 1'b0) bad_stall = 1;
      tick();
    end
    checks++;
    if (bad_stall !== 1'b0) begin
      failures++;
      $display("FAIL valid_drop got stall_violation=%b want 0", bad_stall);
    end
    send_word(0, 64'hA5A5, 1);
    core_ack(1);
    push_r({8{32'h600DF00D}}, 0, 0);
    core_hash({8{32'h600DF00D}});
    tick();
  endtask

  task automatic test_watchdog();
    push_w(64'h77, 1, 1);
    send_word(0, 64'h77, 1);
`ifdef ARB_TIMEOUT_EN
    begin
      logic early;
      early = 0;
      push_r('0, 0, 1);
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        if (res_valid !== 1'b0) early = 1;
      end
      checks++;
      if (early !== 1'b0) begin
        failures++;
        $display("FAIL watchdog_early got early_result=%b want 0", early);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
        failures++;
        $display("FAIL watchdog_fire got res_valid=%b busy=%b grant=%b want 1 0 00", res_valid, busy, grant);
      end
    end
`else
    repeat (40) tick();
    checks++;
    if (busy !== 1'b1 || grant !== 2'b01) begin
      failures++;
      $display("FAIL no_watchdog_hold got busy=%b grant=%b want 1 01", busy, grant);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Serve req0 once so rr points at req1 before the reset.
    push_w(64'h90, 1, 1);
    send_word(0, 64'h90, 1);
    core_ack(1);
    push_r({8{32'h12345678}}, 0, 0);
    core_hash({8{32'h12345678}});
    tick();
    push_w(64'h99, 1, 1);
    send_word(0, 64'h99, 1);
    core_ack(1);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({core_msg, core_msg_valid, core_msg_start, core_msg_last, res_hash, res_valid, res_id, res_err,
         grant, busy, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid got grant=%b busy=%b msg=%h res_valid=%b want all zero", grant, busy, core_msg, res_valid);
    end
    req0_valid = 1; req0_last = 1;
    req1_valid = 1; req1_last = 1;
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL rr_after_reset got grant=%b want 01", grant);
    end
    apply_reset();
    req1_valid = 1; req1_last = 1;
    tick();
    checks++;
    if (grant !== 2'b10 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL lone_req1 got grant=%b rdy1=%b want 10 1", grant, req1_ready);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_truncation();
    test_stray_stall();
    test_watchdog();
    test_reset_mid();
    checks++;
    if (exp_w.size() != 0 || exp_r.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got words_left=%0d results_left=%0d want 0 0", exp_w.size(), exp_r.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_hash_arbiter.md
# ascon_hash_arbiter

Shares the single `ascon_statmachine_top` hash core between two message requesters, for example the host port and the KMAC-output chaining path. Word streams are accepted over valid/ready. A grant is locked for a whole message. The arbiter sequences `msg_in`/`msg_start`/`msg_last` into the core, waits for the digest and returns it tagged with the requester ID. Round-robin fairness, a message-length guard and an optional watchdog keep one requester from starving or hanging the core.

## Interface
- `MAX_WORDS`, default 8: maximum 64-bit words per message.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit; used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1 / `req0_data` in 64 / `req0_last` in 1 / `req0_ready` out 1: requester 0 word stream.
- `req1_valid` in 1 / `req1_data` in 64 / `req1_last` in 1 / `req1_ready` out 1: requester 1 word stream.
- `core_msg` out 64: word to the core.
- `core_msg_valid` out 1: one-cycle pulse; `core_msg` is valid this cycle.
- `core_msg_start` out 1: high with the first word of a message.
- `core_msg_last` out 1: high with the final word of a message.
- `core_word_ack` in 1: core has absorbed the presented word.
- `core_hash_ready` in 1: digest is valid on `core_hash_in`.
- `core_hash_in` in 256: core digest.
- `res_hash` out 256: captured digest.
- `res_valid` out 1: one-cycle result pulse.
- `res_id` out 1: requester the result belongs to.
- `res_err` out 1: qualifies `res_valid`; truncation or timeout occurred.
- `grant` out 2: one-hot owner, 00 when idle.
- `busy` out 1: state ≠ IDLE.

## Operation
- **States:**
  - IDLE → SEND: when either `reqN_valid` is high. The chosen owner is latched into `grant`.
  - SEND → WAIT_ACK: when the granted valid and ready handshake.
  - WAIT_ACK → SEND: on `core_word_ack` for a non-final word.
  - WAIT_ACK → WAIT_HASH: on `core_word_ack` for the final word.
  - WAIT_HASH → IDLE: on `core_hash_ready`.
- **Arbitration:** round-robin pointer `rr`, reset value 0 (requester 0 preferred).
  - Both requesters valid in IDLE: the requester `rr` points to wins.
  - After each result, `rr` points to the requester that was *not* served.
  - A single requester valid: it wins regardless of `rr`.
- **Ready:** `reqN_ready = (state==SEND) && grant[N]`, combinational. A non-granted ready is always 0. If valid drops in SEND, ready stays high and no transfer occurs.
- **Transfer:** on handshake, register `core_msg<=data`.
  - `core_msg_start<=(word_cnt==0)`, `core_msg_last<=last_eff`, `core_msg_valid<=1` for one cycle.
  - `word_cnt` increments, saturating at `MAX_WORDS`.
- **Length guard:** `last_eff = reqN_last || (word_cnt==MAX_WORDS-1)`. A forced last sets a sticky `trunc` flag. The requester's remaining words are then seen as a new message after re-arbitration.
- **Result:** on `core_hash_ready` in WAIT_HASH:
  - `res_hash<=core_hash_in`, `res_id<=owner`, `res_err<=trunc`, `res_valid` pulses.
  - `grant`, `word_cnt` and `trunc` clear.
- **Ignored inputs:** `core_word_ack` outside WAIT_ACK, `core_hash_ready` outside WAIT_HASH, and requester inputs of the non-owner.
- **Width rule:** `word_cnt` is `$clog2(MAX_WORDS+1)` bits.

## Timing
- **Reset values:** all outputs 0, including `res_hash`, `core_msg`, `grant` and `busy`. State IDLE, `rr`=0.
- **Reset mid-operation:** asynchronous return to reset values. No result is emitted; the core must be reset with it.
- **Grant latency:** valid seen in IDLE in cycle 0 → `grant` and `busy` high and ready high in cycle 1. A handshake in cycle 1 → `core_msg_valid` in cycle 2.
- **Word gap:** ack in cycle n → SEND in n+1; the next `core_msg_valid` is in n+2 at the earliest.
- **Result latency:** `core_hash_ready` in cycle m → `res_valid` and IDLE in cycle m+1. The next grant is visible at m+2.
- **Simultaneous ack and hash_ready in WAIT_ACK:** only the ack is acted on.

## Configuration
- **`ARB_TIMEOUT_EN` defined:** a cycle counter clears on every state entry into WAIT_ACK or WAIT_HASH.
  - It counts while in those states.
  - When it reaches `TIMEOUT_CYCLES`, the block emits `res_valid=1`, `res_err=1`, `res_hash=0`, `res_id`=owner, then goes to IDLE and advances `rr`.
- **Undefined:** no counter; the block waits indefinitely in WAIT_ACK and WAIT_HASH.

## Test plan
- **Single message:** req0 sends 2 words `0x11`, `0x22` (last on the second); core acks 3 cycles after each word; `hash_ready` carries `0xAB..AB`.
  - Required: `core_msg_start` only on `0x11`; `core_msg_last` only on `0x22`.
  - Required: `res_valid` one cycle later with `res_id`=0, `res_err`=0, `res_hash`=`0xAB..AB`.
- **Contention:** both requesters valid from reset, each sending 1 word.
  - Required: req0 served first, req1 second.
  - Repeating this keeps alternating, so the third grant goes to req0.
- **Truncation:** req1 streams 9 words with `MAX_WORDS`=8.
  - Required: word 8 carries `core_msg_last`; the result has `res_err`=1 and `res_id`=1.
  - Required: word 9 starts a new message with `core_msg_start`=1.
- **Stray and stalled inputs:** pulse `core_hash_ready` during WAIT_ACK, and drop `req0_valid` in SEND for 4 cycles.
  - Required: no result is emitted and no word is transferred until valid returns.
- **Watchdog** (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): core never acks.
  - Required: after 16 cycles in WAIT_ACK, `res_valid`=1, `res_err`=1, `res_hash`=0, then IDLE.
  - Without the macro, `busy` stays high.
- **Reset mid-operation:** assert `rst_n` low in WAIT_HASH.
  - Required: all outputs are 0 immediately; after release, req1 wins first if only req1 is valid.
